// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction memory between the PC fetch port and a loader/debug port.
// Build option: define LOADER_PRIORITY_EN to let the loader win every simultaneous request.
module imem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic [DATA_W-1:0] fetch_instr,
   output logic              pc_stall,
   input  logic              load_req,
   input  logic              load_we,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_wdata,
   output logic              load_ack,
   output logic [DATA_W-1:0] load_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

   state_t            r_state, w_state_next;
   logic [3:0]        r_cnt, w_cnt_next;
   logic              r_last_load;   // port of the most recent grant; also tags the DONE pulse
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_finstr;
   logic [DATA_W-1:0] r_lrdata;
   logic              w_grant_fetch;
   logic              w_grant_load;
   logic              w_service;

   assign w_service = (r_state == S_FETCH) || (r_state == S_LOAD);

   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_grant_fetch = 1'b0;
      w_grant_load  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (fetch_req && load_req) begin
`ifdef LOADER_PRIORITY_EN
               w_grant_load  = 1'b1;
`else
               w_grant_fetch = r_last_load;
               w_grant_load  = ~r_last_load;
`endif
            end else begin
               w_grant_fetch = fetch_req;
               w_grant_load  = load_req;
            end
            if (w_grant_fetch) begin
               w_state_next = S_FETCH;
               w_cnt_next   = CNT_INIT;
            end else if (w_grant_load) begin
               w_state_next = S_LOAD;
               w_cnt_next   = CNT_INIT;
            end
         end
         S_FETCH, S_LOAD: begin
            if (r_cnt == 4'd0) w_state_next = S_DONE;
            else               w_cnt_next   = r_cnt - 4'd1;
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_last_load <= 1'b1;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_finstr    <= '0;
         r_lrdata    <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_grant_fetch || w_grant_load) begin
            r_last_load <= w_grant_load;
            r_addr      <= w_grant_load ? load_addr : fetch_addr;
            r_we        <= w_grant_load & load_we;
            r_wdata     <= w_grant_load ? load_wdata : '0;
         end
         // Last service cycle: memory data is valid on this edge.
         if (w_service && (r_cnt == 4'd0)) begin
            if (r_state == S_FETCH) r_finstr <= mem_rdata;
            else if (!r_we)         r_lrdata <= mem_rdata;
         end
      end
   end

   assign mem_en      = w_service;
   assign mem_we      = (r_state == S_LOAD) && r_we && (r_cnt == CNT_INIT);
   assign mem_addr    = w_service ? r_addr : '0;
   assign mem_wdata   = w_service ? r_wdata : '0;
   assign fetch_ready = (r_state == S_DONE) && !r_last_load;
   assign load_ack    = (r_state == S_DONE) && r_last_load;
   assign fetch_instr = r_finstr;
   assign load_rdata  = r_lrdata;
   assign busy        = (r_state != S_IDLE);
   assign pc_stall    = fetch_req & ~fetch_ready;
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single instruction memory between the fetch unit (PC-driven fetch port) and a program loader/debug port.
- Sequences each access over a fixed memory latency and returns one-cycle response pulses.
- Drives `pc_stall` so the PC register holds while a fetch is outstanding.
- Sits between the fetch unit/loader and the imem instance.

Parameters:
- ADDR_W, 32, width of all address buses (byte address; bits [1:0] passed through unchanged).
- DATA_W, 32, instruction/data word width.
- MEM_LAT, 2, memory read latency in cycles (legal 1..15); number of service cycles per access.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch request; held high with fetch_addr stable until fetch_ready.
- fetch_addr  in  ADDR_W  fetch address (from PC).
- fetch_ready  out  1  one-cycle pulse: fetch_instr valid.
- fetch_instr  out  DATA_W  registered fetched instruction; holds until next fetch completes.
- pc_stall  out  1  fetch_req & ~fetch_ready (combinational); PC register holds while high.
- load_req  in  1  loader request; held high with load_* stable until load_ack.
- load_we  in  1  1 = write, 0 = read.
- load_addr  in  ADDR_W  loader address.
- load_wdata  in  DATA_W  loader write data.
- load_ack  out  1  one-cycle pulse: write done or load_rdata valid.
- load_rdata  out  DATA_W  registered read data; holds until next loader read completes.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address (latched at grant).
- mem_wdata  out  DATA_W  memory write data (latched at grant).
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en rises.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - state = IDLE; last_grant = LOAD, so fetch wins the first tie.
  - All outputs 0; fetch_instr and load_rdata = 0.
  - mem_we drops immediately on rst assertion (asynchronous).
- States: IDLE, FETCH, LOAD, DONE.
- IDLE:
  - Only fetch_req high -> FETCH. Only load_req high -> LOAD.
  - Both high -> round robin: grant the port not in last_grant.
  - Neither high -> stay in IDLE.
  - On grant: latch address, we and wdata into mem_* registers; update last_grant; load counter with MEM_LAT-1.
- FETCH / LOAD (service):
  - mem_en = 1 for exactly MEM_LAT cycles.
  - mem_we = load_we in the first service cycle only (LOAD only); mem_we is never 1 in FETCH.
  - Counter decrements each cycle. At counter 0: capture mem_rdata into fetch_instr (FETCH) or into load_rdata (LOAD, read only); go to DONE.
- DONE:
  - Pulse fetch_ready or load_ack for exactly one cycle; mem_en = 0; no grant is issued.
  - Next state is IDLE.
  - Requester must drop req by the edge leaving DONE. A req still high in IDLE is treated as a new request.
- Latency: req sampled high in IDLE at edge k -> ack/ready high during cycle k+MEM_LAT+1. Minimum spacing of back-to-back grants is MEM_LAT+2 cycles.
- Inputs are ignored outside IDLE. Changing fetch_addr/load_* mid-service has no effect (values were latched).
- A loader write to an address being fetched has no hazard check; accesses are ordered strictly by grant order.
- rst asserted mid-operation: transaction abandoned, state -> IDLE, no ack issued, registered data returned to 0.
- fetch_req low and load_req low in IDLE: all memory outputs 0 and busy = 0.

Optional Feature:
- Macro LOADER_PRIORITY_EN.
- Defined: when both ports request in IDLE, the loader always wins; last_grant is ignored. Fetch can be starved while the loader streams, which is used to freeze the CPU during boot/debug loads.
- Undefined: round robin as specified above.

Test Plan:
- Single fetch, MEM_LAT=2: fetch_req=1, fetch_addr=0x0000_0040, mem returns 0x2002_0005 -> mem_en high 2 cycles with mem_addr=0x40; fetch_ready pulses 3 cycles after the sampling edge; fetch_instr=0x2002_0005; pc_stall high for 3 cycles then low.
- Loader write: load_req=1, load_we=1, addr 0x100, wdata 0xDEAD_BEEF -> mem_we high exactly 1 cycle with those values; load_ack 3 cycles later; fetch_ready never pulses.
- Tie after reset, both requesting continuously (requesters re-raise after each ack) -> grant order FETCH, LOAD, FETCH, LOAD; with LOADER_PRIORITY_EN -> LOAD, LOAD, LOAD.
- Loader read 0x104 returning 0x1234_5678, then a fetch returning 0x0800_0010 -> load_rdata stays 0x1234_5678 while fetch_instr becomes 0x0800_0010.
- rst pulsed during the 2nd service cycle of a loader write -> mem_we/mem_en drop immediately; no load_ack; busy=0; next request completes normally.
- MEM_LAT=1 fetch, then fetch_addr changed during service -> mem_addr keeps the original address; fetch_ready 2 cycles after the sampling edge.
